ring_phase_decoder: RTL and testbench

//   Receive-side monitor for the N-bit one-hot ring counter. Samples the ring

---
 rtl/ring_phase_decoder.sv | 145 ++++++++++++++
 tb/tb_ring_phase_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ring_phase_decoder.sv
// Receive-side checker/decoder for an N-bit one-hot ring counter: decodes the
// phase index, qualifies the stream with a lock FSM and counts sequence errors.
module ring_phase_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ring_in,
    input  logic             ring_vld,
    output logic [IDX_W-1:0] phase_idx,
    output logic             phase_vld,
    output logic             locked,
    output logic             err,
    output logic             wrap,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_CNT_C = 4'(LOCK_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_one_hot(input logic [N-1:0] v);
        return (v != {N{1'b0}}) && ((v & (v - N'(1))) == {N{1'b0}});
    endfunction

    function automatic logic [IDX_W-1:0] bit_index(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [3:0]       good_r, good_nxt_s;
    logic [IDX_W-1:0] exp_idx_r, exp_idx_nxt_s;
    logic [ERR_W-1:0] err_cnt_nxt_s;
    logic             err_nxt_s, wrap_nxt_s;
    logic             one_hot_s, match_s;
    logic [IDX_W-1:0] idx_s;

    // Sample decode: one-hot test, bit position, expected-position match.
    always_comb begin
        one_hot_s     = is_one_hot(ring_in);
        idx_s         = bit_index(ring_in);
        match_s       = one_hot_s && (idx_s == exp_idx_r);
        exp_idx_nxt_s = (idx_s == IDX_LAST) ? {IDX_W{1'b0}} : idx_s + IDX_W'(1);
    end

    // Lock FSM next-state, error/wrap pulses and saturating error count.
    always_comb begin
        state_nxt_s   = state_r;
        good_nxt_s    = good_r;
        err_nxt_s     = 1'b0;
        wrap_nxt_s    = 1'b0;
        err_cnt_nxt_s = err_cnt;
        if (ring_vld) begin
            case (state_r)
                ST_SEARCH: begin
                    if (one_hot_s) begin
                        good_nxt_s  = 4'd1;
                        state_nxt_s = (LOCK_CNT_C == 4'd1) ? ST_LOCKED : ST_CONFIRM;
                    end else begin
                        good_nxt_s  = 4'd0;
                    end
                end
                ST_CONFIRM: begin
                    if (match_s) begin
                        good_nxt_s = good_r + 4'd1;
                        if ((good_r + 4'd1) >= LOCK_CNT_C) begin
                            state_nxt_s = ST_LOCKED;
                        end else begin
                            state_nxt_s = ST_CONFIRM;
                        end
                    end else if (one_hot_s) begin
                        // A clean jump re-seeds qualification at the new position.
                        good_nxt_s = 4'd1;
                    end else begin
                        good_nxt_s  = 4'd0;
                        state_nxt_s = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        wrap_nxt_s = (idx_s == {IDX_W{1'b0}});
                    end else begin
                        err_nxt_s     = 1'b1;
                        err_cnt_nxt_s = (err_cnt == ERR_MAX) ? ERR_MAX : err_cnt + ERR_W'(1);
                        good_nxt_s    = 4'd0;
                        state_nxt_s   = ST_SEARCH;
                    end
                end
                default: begin
                    good_nxt_s  = 4'd0;
                    state_nxt_s = ST_SEARCH;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State, expected-index and registered output updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_SEARCH;
            good_r    <= 4'd0;
            exp_idx_r <= {IDX_W{1'b0}};
            phase_idx <= {IDX_W{1'b0}};
            phase_vld <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            err_cnt   <= {ERR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            good_r  <= good_nxt_s;
            if (ring_vld && one_hot_s) begin
                phase_idx <= idx_s;
                phase_vld <= 1'b1;
                exp_idx_r <= exp_idx_nxt_s;
            end else begin
                phase_vld <= 1'b0;
            end
            locked  <= (state_nxt_s == ST_LOCKED);
            err     <= err_nxt_s;
            wrap    <= wrap_nxt_s;
            err_cnt <= err_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_ring_phase_decoder.sv
// Scoreboarded bench for ring_phase_decoder: directed scenarios then random
// ring streams, each compared against a lock-counter reference model.
module tb_ring_phase_decoder;

    localparam int N        = 4;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 2;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    typedef struct {
        int pidx;
        int pvld;
        int lck;
        int er;
        int wr;
        int cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     ring_in = '0;
    logic             ring_vld = 1'b0;
    logic [1:0]       phase_idx;
    logic             phase_vld, locked, err, wrap;
    logic [ERR_W-1:0] err_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: run length of good samples (>= LOCK_CNT means locked).
    int m_good = 0;
    int m_exp  = 0;
    int m_pidx = 0;
    int m_cnt  = 0;

    ring_phase_decoder #(.N(N), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
        .phase_idx(phase_idx), .phase_vld(phase_vld), .locked(locked),
        .err(err), .wrap(wrap), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus and queue the response expected after the edge.
    task automatic step(input logic r, input logic v, input logic [N-1:0] ring);
        exp_t e;
        int   idx;
        bit   oh, match, was_locked;
        @(negedge clk);
        rst = r; ring_vld = v; ring_in = ring;
        e.er = 0; e.wr = 0; e.pvld = 0;
        if (r) begin
            m_good = 0; m_exp = 0; m_pidx = 0; m_cnt = 0;
        end else if (v) begin
            oh  = ($countones(ring) == 1);
            idx = 0;
            for (int i = 0; i < N; i++) if (ring[i]) idx = i;
            match      = oh && (idx == m_exp);
            was_locked = (m_good >= LOCK_CNT);
            if (was_locked) begin
                if (match) e.wr = (idx == 0);
                else begin
                    e.er   = 1;
                    m_cnt  = (m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX;
                    m_good = 0;
                end
            end else if (!oh)       m_good = 0;
            else if (m_good == 0)   m_good = 1;
            else if (match)         m_good = m_good + 1;
            else                    m_good = 1;
            if (oh) begin
                m_pidx = idx; e.pvld = 1; m_exp = (idx + 1) % N;
            end
        end
        e.pidx = m_pidx;
        e.lck  = (m_good >= LOCK_CNT) ? 1 : 0;
        e.cnt  = m_cnt;
        q.push_back(e);
    endtask

    task automatic seq(input logic v, input logic [N-1:0] ring);
        step(1'b0, v, ring);
    endtask

    // Monitor: after each edge, pop the pending expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (int'(phase_idx) !== e.pidx || int'(phase_vld) !== e.pvld ||
                    int'(locked) !== e.lck || int'(err) !== e.er ||
                    int'(wrap) !== e.wr || int'(err_cnt) !== e.cnt) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got idx=%0d vld=%0d lck=%0d err=%0d wrap=%0d cnt=%0d required idx=%0d vld=%0d lck=%0d err=%0d wrap=%0d cnt=%0d",
                             $time, phase_idx, phase_vld, locked, err, wrap, err_cnt,
                             e.pidx, e.pvld, e.lck, e.er, e.wr, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] one;
        logic [N-1:0] ring;
        one = 4'b0001;
        // Reset with random inputs
        for (int i = 0; i < 2; i++) step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        // Lock and wrap
        seq(1'b1, 4'b0001); seq(1'b1, 4'b0010); seq(1'b1, 4'b0100);
        seq(1'b1, 4'b1000); seq(1'b1, 4'b0001);
        // Error while locked, then relock
        seq(1'b1, 4'b0100);
        seq(1'b1, 4'b1000); seq(1'b1, 4'b0001); seq(1'b1, 4'b0010);
        // Invalid patterns
        seq(1'b1, 4'b0000); seq(1'b1, 4'b0110);
        // Gapped valid, then re-seed inside CONFIRM
        step(1'b1, 1'b0, 4'b0000);
        seq(1'b1, 4'b0001); seq(1'b0, 4'b1111); seq(1'b1, 4'b0010);
        seq(1'b0, 4'b0101); seq(1'b1, 4'b0100); seq(1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        seq(1'b1, 4'b0001); seq(1'b1, 4'b0010); seq(1'b1, 4'b1000);
        seq(1'b1, 4'b0001); seq(1'b1, 4'b0010); seq(1'b1, 4'b0010);
        // Saturation with five errors, then reset while locked
        step(1'b1, 1'b0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            seq(1'b1, 4'b0001); seq(1'b1, 4'b0010); seq(1'b1, 4'b0100);
            seq(1'b1, 4'b0000);
        end
        seq(1'b1, 4'b0001); seq(1'b1, 4'b0010); seq(1'b1, 4'b0100);
        step(1'b1, 1'b1, 4'b1000);
        seq(1'b1, 4'b0001);
        // Random streams: mostly correct advance, some jumps and garbage
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 80)      ring = one << m_exp;
            else if (sel < 90) ring = one << $urandom_range(0, N - 1);
            else               ring = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), ring);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain got %0d pending required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
